// File: rtl/mtap_tdomux_pkg.sv
// Shared types and sizing for the mTAP TDO mux and its retiming pipeline.
// Holds the FSM state encoding and the flush-counter width sized for the deepest supported pipeline.
package mtap_tdomux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2
   } tdomux_state_t;

   localparam int MAX_PIPE_STAGES = 8;
   localparam int FLUSH_CNT_W     = $clog2(MAX_PIPE_STAGES);

endpackage

// File: rtl/mtap_tdomux_pipe_if.sv
// TAP-side bundle between the mTAP FSM/IR decoder and the TDO mux.
// The master side drives FSM state and shift data; the slave side returns TDO, pad enable and select error.
interface mtap_tdomux_pipe_if #(
   parameter int NUM_REGS  = 8,
   parameter int NUM_CHILD = 2
);
   logic                 mtap_fsm_tlrs;
   logic                 mtap_fsm_shift_ir;
   logic                 mtap_fsm_shift_dr;
   logic                 mtap_irreg_serial_out;
   logic [NUM_REGS-1:0]  mtap_drreg_drout;
   logic [NUM_REGS-1:0]  mtap_irdecoder_drselect;
   logic [NUM_CHILD-1:0] mtap_child_select;
   logic [NUM_CHILD-1:0] mtap_child_tdo;
   logic                 mtap_mux_tdo;
   logic                 mtap_tdomux_tdoen;
   logic                 mtap_tdomux_sel_err;

   modport master (
      output mtap_fsm_tlrs, mtap_fsm_shift_ir, mtap_fsm_shift_dr, mtap_irreg_serial_out,
             mtap_drreg_drout, mtap_irdecoder_drselect, mtap_child_select, mtap_child_tdo,
      input  mtap_mux_tdo, mtap_tdomux_tdoen, mtap_tdomux_sel_err
   );

   modport slave (
      input  mtap_fsm_tlrs, mtap_fsm_shift_ir, mtap_fsm_shift_dr, mtap_irreg_serial_out,
             mtap_drreg_drout, mtap_irdecoder_drselect, mtap_child_select, mtap_child_tdo,
      output mtap_mux_tdo, mtap_tdomux_tdoen, mtap_tdomux_sel_err
   );
endinterface

// File: rtl/mtap_tdo_pipe.sv
// Negedge-TCK TDO retiming pipeline with drain FSM and registered pad enable.
// A bit taken at negedge k reaches dout after negedge k+PIPE_STAGES-1; TCK-paced, no backpressure.
module mtap_tdo_pipe
   import mtap_tdomux_pkg::*;
#(
   parameter int PIPE_STAGES = 1
) (
   input  logic tck,
   input  logic trst_b,
   input  logic tlrs,
   input  logic shift,
   input  logic din,
   output logic dout,
   output logic tdoen
);
   tdomux_state_t          state;
   logic [PIPE_STAGES-1:0] pipe;
   logic [FLUSH_CNT_W-1:0] flush_cnt;

   always_ff @(negedge tck or negedge trst_b) begin
      if (!trst_b) begin
         state     <= IDLE;
         pipe      <= '0;
         flush_cnt <= '0;
         tdoen     <= 1'b0;
      end else if (tlrs) begin
         state     <= IDLE;
         pipe      <= '0;
         flush_cnt <= '0;
         tdoen     <= 1'b0;
      end else begin
         // Stage 0 takes live data while shifting and zeros while draining.
         if (shift)
            pipe[0] <= din;
         else if (state != IDLE)
            pipe[0] <= 1'b0;
         if (state != IDLE)
            for (int i = 1; i < PIPE_STAGES; i++)
               pipe[i] <= pipe[i-1];

         case (state)
            IDLE: begin
               if (shift) begin
                  state <= SHIFT;
                  tdoen <= 1'b1;
               end
            end
            SHIFT: begin
               if (!shift) begin
                  if (PIPE_STAGES > 1) begin
                     state     <= FLUSH;
                     flush_cnt <= FLUSH_CNT_W'(PIPE_STAGES - 1);
                  end else begin
                     state <= IDLE;
                     tdoen <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (shift) begin
                  state     <= SHIFT;
                  flush_cnt <= '0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
                  if (flush_cnt == FLUSH_CNT_W'(1)) begin
                     state <= IDLE;
                     tdoen <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tdoen <= 1'b0;
            end
         endcase
      end
   end

   assign dout = pipe[PIPE_STAGES-1];

endmodule

// File: rtl/mtap_tdomux_pipe.sv
// mTAP TDO source mux (IR, secondary TAP, or one-hot DR) with sticky illegal-select flag, feeding the retimer.
// Output latency PIPE_STAGES-1 negedges after selection; TCK-paced, no backpressure.
module mtap_tdomux_pipe
   import mtap_tdomux_pkg::*;
#(
   parameter int NUM_REGS    = 8,
   parameter int NUM_CHILD   = 2,
   parameter int PIPE_STAGES = 1
) (
   input logic              atappris_tck,
   input logic              powergoodrst_trst_b,
   mtap_tdomux_pipe_if.slave tap_if
);
   logic [NUM_REGS-1:0]  drselect;
   logic [NUM_REGS-1:0]  drout;
   logic [NUM_CHILD-1:0] child_select;
   logic [NUM_CHILD-1:0] child_tdo;
   logic                 shift_ir;
   logic                 shift_dr;
   logic                 shift;
   logic                 sel_bit;
   logic                 sel_err_set;
   logic                 sel_err;
   logic                 pipe_tdo;
   logic                 pipe_tdoen;

   assign drselect     = tap_if.mtap_irdecoder_drselect;
   assign drout        = tap_if.mtap_drreg_drout;
   assign child_select = tap_if.mtap_child_select;
   assign child_tdo    = tap_if.mtap_child_tdo;
   assign shift_ir     = tap_if.mtap_fsm_shift_ir;
   assign shift_dr     = tap_if.mtap_fsm_shift_dr;

   // Priority still resolves to a defined bit when the select is illegal.
   always_comb begin
      shift = shift_ir | shift_dr;
      if (shift_ir)
         sel_bit = tap_if.mtap_irreg_serial_out;
      else if (|child_select)
         sel_bit = |(child_select & child_tdo);
      else
         sel_bit = |(drselect & drout);
      sel_err_set = (shift_ir & shift_dr)
                  | (shift & ($countones(child_select) > 1))
                  | (shift_dr & ~(|child_select) & ($countones(drselect) != 1));
   end

   always_ff @(negedge atappris_tck or negedge powergoodrst_trst_b) begin
      if (!powergoodrst_trst_b)
         sel_err <= 1'b0;
      else if (tap_if.mtap_fsm_tlrs)
         sel_err <= 1'b0;
      else if (sel_err_set)
         sel_err <= 1'b1;
   end

   mtap_tdo_pipe #(
      .PIPE_STAGES (PIPE_STAGES)
   ) u_tdo_pipe (
      .tck    (atappris_tck),
      .trst_b (powergoodrst_trst_b),
      .tlrs   (tap_if.mtap_fsm_tlrs),
      .shift  (shift),
      .din    (sel_bit),
      .dout   (pipe_tdo),
      .tdoen  (pipe_tdoen)
   );

   assign tap_if.mtap_mux_tdo        = pipe_tdo;
   assign tap_if.mtap_tdomux_tdoen   = pipe_tdoen;
   assign tap_if.mtap_tdomux_sel_err = sel_err;

endmodule

// File: tb/tb_mtap_tdomux_pipe.sv
// Directed bench for mtap_tdomux_pipe: three instances (PIPE_STAGES 1, 3, 4) share one stimulus stream.
module tb_mtap_tdomux_pipe;

   logic       tck;
   logic       trst_b;
   logic       tlrs, sir, sdr, ir_out;
   logic [7:0] drout, drsel;
   logic [1:0] csel, ctdo;

   int errors = 0;
   int checks = 0;

   mtap_tdomux_pipe_if #(.NUM_REGS(8), .NUM_CHILD(2)) if1 ();
   mtap_tdomux_pipe_if #(.NUM_REGS(8), .NUM_CHILD(2)) if3 ();
   mtap_tdomux_pipe_if #(.NUM_REGS(8), .NUM_CHILD(2)) if4 ();

   assign if1.mtap_fsm_tlrs = tlrs;            assign if3.mtap_fsm_tlrs = tlrs;            assign if4.mtap_fsm_tlrs = tlrs;
   assign if1.mtap_fsm_shift_ir = sir;         assign if3.mtap_fsm_shift_ir = sir;         assign if4.mtap_fsm_shift_ir = sir;
   assign if1.mtap_fsm_shift_dr = sdr;         assign if3.mtap_fsm_shift_dr = sdr;         assign if4.mtap_fsm_shift_dr = sdr;
   assign if1.mtap_irreg_serial_out = ir_out;  assign if3.mtap_irreg_serial_out = ir_out;  assign if4.mtap_irreg_serial_out = ir_out;
   assign if1.mtap_drreg_drout = drout;        assign if3.mtap_drreg_drout = drout;        assign if4.mtap_drreg_drout = drout;
   assign if1.mtap_irdecoder_drselect = drsel; assign if3.mtap_irdecoder_drselect = drsel; assign if4.mtap_irdecoder_drselect = drsel;
   assign if1.mtap_child_select = csel;        assign if3.mtap_child_select = csel;        assign if4.mtap_child_select = csel;
   assign if1.mtap_child_tdo = ctdo;           assign if3.mtap_child_tdo = ctdo;           assign if4.mtap_child_tdo = ctdo;

   mtap_tdomux_pipe #(.NUM_REGS(8), .NUM_CHILD(2), .PIPE_STAGES(1)) dut1 (
      .atappris_tck(tck), .powergoodrst_trst_b(trst_b), .tap_if(if1));
   mtap_tdomux_pipe #(.NUM_REGS(8), .NUM_CHILD(2), .PIPE_STAGES(3)) dut3 (
      .atappris_tck(tck), .powergoodrst_trst_b(trst_b), .tap_if(if3));
   mtap_tdomux_pipe #(.NUM_REGS(8), .NUM_CHILD(2), .PIPE_STAGES(4)) dut4 (
      .atappris_tck(tck), .powergoodrst_trst_b(trst_b), .tap_if(if4));

   initial begin
      tck = 1'b1;
      forever #5 tck = ~tck;
   end

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   // One negedge of DUT activity, then return at the following posedge for sampling/driving.
   task automatic tick();
      @(negedge tck);
      @(posedge tck);
   endtask

   task automatic idle_inputs();
      tlrs = 0; sir = 0; sdr = 0; ir_out = 0;
      drout = '0; drsel = '0; csel = '0; ctdo = '0;
   endtask

   logic [4:0]  pat1;
   logic [3:0]  irp;
   logic [7:0]  e2_tdo3, e2_en3, e2_tdo4, e2_en4;
   logic [11:0] s3_shift, s3_data, e3_tdo, e3_en;

   initial begin
      pat1     = 5'b01101;
      irp      = 4'b1101;
      e2_tdo3  = 8'b0011_0100;
      e2_en3   = 8'b0011_1111;
      e2_tdo4  = 8'b0110_1000;
      e2_en4   = 8'b0111_1111;
      s3_shift = 12'h0EF;
      s3_data  = 12'h0CB;
      e3_tdo   = 12'h32C;
      e3_en    = 12'h3FF;

      // Reset state
      trst_b = 1'b0;
      idle_inputs();
      #2;
      chk("rst_tdo1", if1.mtap_mux_tdo, 1'b0);
      chk("rst_en1", if1.mtap_tdomux_tdoen, 1'b0);
      chk("rst_err1", if1.mtap_tdomux_sel_err, 1'b0);
      chk("rst_tdo3", if3.mtap_mux_tdo, 1'b0);
      chk("rst_en3", if3.mtap_tdomux_tdoen, 1'b0);
      chk("rst_en4", if4.mtap_tdomux_tdoen, 1'b0);
      @(posedge tck);
      trst_b = 1'b1;

      // 1: 5-bit Shift-DR from DR2, legacy timing
      drsel = 8'h04;
      sdr   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drout = {5'b0, pat1[k], 2'b0};
         tick();
         chk("t1_tdo1", if1.mtap_mux_tdo, pat1[k]);
         chk("t1_en1", if1.mtap_tdomux_tdoen, 1'b1);
         chk("t1_err1", if1.mtap_tdomux_sel_err, 1'b0);
         if (k >= 2) chk("t1_tdo3", if3.mtap_mux_tdo, pat1[k-2]);
      end
      sdr = 1'b0; drout = '0;
      tick();
      chk("t1_en1_off", if1.mtap_tdomux_tdoen, 1'b0);
      chk("t1_tdo3_drain", if3.mtap_mux_tdo, pat1[3]);
      chk("t1_en3_flush", if3.mtap_tdomux_tdoen, 1'b1);
      idle_inputs();
      repeat (6) tick();

      // 2: Shift-IR 1011 through 3- and 4-deep pipelines
      for (int t = 0; t < 8; t++) begin
         if (t < 4) begin sir = 1'b1; ir_out = irp[t]; end
         else begin sir = 1'b0; ir_out = 1'b0; end
         tick();
         if (t < 4) chk("t2_tdo1", if1.mtap_mux_tdo, irp[t]);
         chk("t2_tdo3", if3.mtap_mux_tdo, e2_tdo3[t]);
         chk("t2_en3", if3.mtap_tdomux_tdoen, e2_en3[t]);
         chk("t2_tdo4", if4.mtap_mux_tdo, e2_tdo4[t]);
         chk("t2_en4", if4.mtap_tdomux_tdoen, e2_en4[t]);
      end
      chk("t2_err3", if3.mtap_tdomux_sel_err, 1'b0);
      idle_inputs();
      repeat (6) tick();

      // 3: shift drops for one negedge and re-asserts during FLUSH
      drsel = 8'h01;
      for (int t = 0; t < 12; t++) begin
         sdr   = s3_shift[t];
         drout = {7'b0, s3_data[t]};
         tick();
         chk("t3_tdo3", if3.mtap_mux_tdo, e3_tdo[t]);
         chk("t3_en3", if3.mtap_tdomux_tdoen, e3_en[t]);
      end
      chk("t3_err3", if3.mtap_tdomux_sel_err, 1'b0);
      idle_inputs();
      repeat (6) tick();

      // 4: secondary TAP selection, IR priority, multi-hot child select
      sdr = 1'b1; drsel = 8'h01; drout = 8'h00; csel = 2'b10; ctdo = 2'b10;
      tick();
      chk("t4_child_tdo", if1.mtap_mux_tdo, 1'b1);
      chk("t4_child_err", if1.mtap_tdomux_sel_err, 1'b0);
      ctdo = 2'b01;
      tick();
      chk("t4_child_mask", if1.mtap_mux_tdo, 1'b0);
      sir = 1'b1; ir_out = 1'b1; ctdo = 2'b00;
      tick();
      chk("t4_ir_prio", if1.mtap_mux_tdo, 1'b1);
      sir = 1'b0; ir_out = 1'b0;
      csel = 2'b11; ctdo = 2'b01;
      tick();
      chk("t4_multi_err", if1.mtap_tdomux_sel_err, 1'b1);
      chk("t4_multi_tdo", if1.mtap_mux_tdo, 1'b1);
      sdr = 1'b0; csel = 2'b00; ctdo = 2'b00;
      repeat (3) tick();
      chk("t4_sticky", if1.mtap_tdomux_sel_err, 1'b1);
      tlrs = 1'b1;
      tick();
      tlrs = 1'b0;
      chk("t4_tlrs_err", if1.mtap_tdomux_sel_err, 1'b0);
      csel = 2'b11;
      tick();
      chk("t4_noshift_err", if1.mtap_tdomux_sel_err, 1'b0);
      csel = 2'b00;

      // 5: non-one-hot DR select, tlrs clear, IR+DR conflict
      drsel = 8'h06;
      tick();
      chk("t5_noshift_dr", if1.mtap_tdomux_sel_err, 1'b0);
      sdr = 1'b1; drout = 8'h02;
      tick();
      chk("t5_dr_err", if1.mtap_tdomux_sel_err, 1'b1);
      chk("t5_dr_tdo", if1.mtap_mux_tdo, 1'b1);
      chk("t5_dr_en", if1.mtap_tdomux_tdoen, 1'b1);
      tlrs = 1'b1;
      tick();
      chk("t5_tlrs_err", if1.mtap_tdomux_sel_err, 1'b0);
      chk("t5_tlrs_tdo", if1.mtap_mux_tdo, 1'b0);
      chk("t5_tlrs_en", if1.mtap_tdomux_tdoen, 1'b0);
      chk("t5_tlrs_en3", if3.mtap_tdomux_tdoen, 1'b0);
      tlrs = 1'b0; sir = 1'b1; sdr = 1'b1; drsel = 8'h01; drout = 8'h01; ir_out = 1'b0;
      tick();
      chk("t5_irdr_tdo", if1.mtap_mux_tdo, 1'b0);
      chk("t5_irdr_err", if1.mtap_tdomux_sel_err, 1'b1);
      tlrs = 1'b1; sir = 1'b0; sdr = 1'b0;
      tick();
      tlrs = 1'b0;
      chk("t5_clear2", if1.mtap_tdomux_sel_err, 1'b0);
      sdr = 1'b1; drsel = 8'h00; drout = 8'hFF;
      tick();
      chk("t5_nosel_err", if1.mtap_tdomux_sel_err, 1'b1);
      chk("t5_nosel_tdo", if1.mtap_mux_tdo, 1'b0);
      sdr = 1'b0; tlrs = 1'b1;
      tick();
      idle_inputs();
      repeat (6) tick();

      // 6: async reset while the 4-deep pipeline is flushing
      sdr = 1'b1; drsel = 8'h03; drout = 8'h01;
      repeat (4) tick();
      chk("t6_pre_tdo4", if4.mtap_mux_tdo, 1'b1);
      chk("t6_pre_err4", if4.mtap_tdomux_sel_err, 1'b1);
      sdr = 1'b0;
      tick();
      chk("t6_flush_tdo4", if4.mtap_mux_tdo, 1'b1);
      chk("t6_flush_en4", if4.mtap_tdomux_tdoen, 1'b1);
      #2;
      trst_b = 1'b0;
      #1;
      chk("t6_rst_tdo4", if4.mtap_mux_tdo, 1'b0);
      chk("t6_rst_en4", if4.mtap_tdomux_tdoen, 1'b0);
      chk("t6_rst_err4", if4.mtap_tdomux_sel_err, 1'b0);
      @(posedge tck);
      trst_b = 1'b1; drsel = 8'h01; drout = 8'h00; sdr = 1'b1;
      for (int t = 0; t < 8; t++) begin
         if (t == 4) sdr = 1'b0;
         tick();
         if (t < 4) chk("t6_zero_tdo4", if4.mtap_mux_tdo, 1'b0);
         chk("t6_en4", if4.mtap_tdomux_tdoen, (t < 7) ? 1'b1 : 1'b0);
      end
      chk("t6_err4", if4.mtap_tdomux_sel_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
